// File: rtl/writeback_merge_pkg.sv
// Shared types and defaults for the multi-source writeback stage.
// Default widths match the core's thread/register/vector configuration.
package writeback_merge_pkg;

    localparam int VECTOR_LANES    = 16;
    localparam int THREAD_IDX_BITS = 2;
    localparam int REG_IDX_BITS    = 5;

    typedef logic [THREAD_IDX_BITS-1:0] thread_idx_t;
    typedef logic [REG_IDX_BITS-1:0]    register_idx_t;
    typedef logic [31:0]                scalar_t;
    typedef scalar_t [VECTOR_LANES-1:0] vector_t;

    typedef struct packed {
        thread_idx_t              thread;
        logic                     is_vector;
        register_idx_t            reg_idx;
        logic [VECTOR_LANES-1:0]  mask;
        vector_t                  value;
    } wb_entry_t;

    // Width of an index into n items; never zero so ports stay legal.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/writeback_merge_if.sv
// Result-source and writeback/rollback bundle for writeback_merge.
// slave is the merge stage, master is whoever drives the sources.
interface writeback_merge_if
    import writeback_merge_pkg::*;
#(
    parameter int NUM_SOURCES     = 3,
    parameter int NUM_LANES       = VECTOR_LANES,
    parameter int THREAD_IDX_BITS = writeback_merge_pkg::THREAD_IDX_BITS,
    parameter int REG_IDX_BITS    = writeback_merge_pkg::REG_IDX_BITS
);
    localparam int SW = idx_bits(NUM_SOURCES);

    logic [NUM_SOURCES-1:0]                       src_valid;
    logic [NUM_SOURCES-1:0]                       src_ready;
    logic [NUM_SOURCES-1:0]                       src_has_dest;
    logic [NUM_SOURCES-1:0]                       src_is_vector;
    logic [NUM_SOURCES-1:0]                       src_is_compare;
    logic [NUM_SOURCES-1:0][THREAD_IDX_BITS-1:0]  src_thread;
    logic [NUM_SOURCES-1:0][REG_IDX_BITS-1:0]     src_reg;
    logic [NUM_SOURCES-1:0][NUM_LANES-1:0]        src_mask;
    logic [NUM_SOURCES-1:0][NUM_LANES-1:0][31:0]  src_value;
    logic [NUM_SOURCES-1:0]                       src_rollback_en;
    logic [NUM_SOURCES-1:0][31:0]                 src_rollback_pc;

    logic                                         wb_rollback_en;
    logic [THREAD_IDX_BITS-1:0]                   wb_rollback_thread_idx;
    logic [31:0]                                  wb_rollback_pc;
    logic [SW-1:0]                                wb_rollback_source;

    logic                                         wb_en;
    logic [THREAD_IDX_BITS-1:0]                   wb_thread_idx;
    logic                                         wb_is_vector;
    logic [REG_IDX_BITS-1:0]                      wb_reg;
    logic [NUM_LANES-1:0]                         wb_mask;
    logic [NUM_LANES-1:0][31:0]                   wb_value;

    modport master (
        output src_valid, src_has_dest, src_is_vector, src_is_compare,
        output src_thread, src_reg, src_mask, src_value,
        output src_rollback_en, src_rollback_pc,
        input  src_ready,
        input  wb_rollback_en, wb_rollback_thread_idx,
        input  wb_rollback_pc, wb_rollback_source,
        input  wb_en, wb_thread_idx, wb_is_vector,
        input  wb_reg, wb_mask, wb_value
    );

    modport slave (
        input  src_valid, src_has_dest, src_is_vector, src_is_compare,
        input  src_thread, src_reg, src_mask, src_value,
        input  src_rollback_en, src_rollback_pc,
        output src_ready,
        output wb_rollback_en, wb_rollback_thread_idx,
        output wb_rollback_pc, wb_rollback_source,
        output wb_en, wb_thread_idx, wb_is_vector,
        output wb_reg, wb_mask, wb_value
    );

endinterface

// File: rtl/writeback_fifo.sv
// Per-source result FIFO; power-of-two depth, extra pointer MSB
// distinguishes full from empty.
module writeback_fifo
    import writeback_merge_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = idx_bits(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/writeback_merge.sv
// Merges NUM_SOURCES result pipelines onto one register write port
// via per-source FIFOs and a round-robin drain; resolves rollbacks.
module writeback_merge
    import writeback_merge_pkg::*;
#(
    parameter int NUM_SOURCES     = 3,
    parameter int NUM_LANES       = VECTOR_LANES,
    parameter int FIFO_DEPTH      = 2,
    parameter int THREAD_IDX_BITS = writeback_merge_pkg::THREAD_IDX_BITS,
    parameter int REG_IDX_BITS    = writeback_merge_pkg::REG_IDX_BITS
) (
    input logic              clk,
    input logic              reset,
    writeback_merge_if.slave bus
);
    localparam int SW = idx_bits(NUM_SOURCES);
    localparam int VW = NUM_LANES * 32;

    typedef struct packed {
        logic [THREAD_IDX_BITS-1:0] thread;
        logic                       is_vector;
        logic [REG_IDX_BITS-1:0]    reg_idx;
        logic [NUM_LANES-1:0]       mask;
        logic [VW-1:0]              value;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [NUM_SOURCES-1:0]         push;
    logic [NUM_SOURCES-1:0]         pop;
    logic [NUM_SOURCES-1:0]         empty;
    logic [NUM_SOURCES-1:0]         full;
    logic [NUM_SOURCES-1:0][EW-1:0] head;

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] grant;
    logic          grant_valid;
    logic [SW:0]   cand;
    logic [SW-1:0] next_ptr;

    logic          wb_en_q;
    entry_t        out_q;

    assign bus.src_ready = ~full;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
        logic [VW-1:0] val;
        entry_t        din;

        // Compare results collapse to a lane mask in the low bits.
        always_comb begin
            val = '0;
            if (bus.src_is_compare[g]) begin
                for (int k = 0; k < NUM_LANES; k++)
                    val[k] = bus.src_value[g][k][0];
            end else begin
                val = bus.src_value[g];
            end
        end

        always_comb begin
            din.thread    = bus.src_thread[g];
            din.is_vector = bus.src_is_vector[g];
            din.reg_idx   = bus.src_reg[g];
            din.mask      = bus.src_mask[g];
            din.value     = val;
        end

        assign push[g] = bus.src_valid[g] && bus.src_ready[g] &&
                         bus.src_has_dest[g] &&
                         !bus.src_rollback_en[g];

        writeback_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din),
            .dout  (head[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    // Scan from rr_ptr upward; descending loop lets the nearest win.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int j = NUM_SOURCES - 1; j >= 0; j--) begin
            cand = {1'b0, rr_ptr} + (SW+1)'(j);
            if (cand >= (SW+1)'(NUM_SOURCES))
                cand = cand - (SW+1)'(NUM_SOURCES);
            if (!empty[cand[SW-1:0]]) begin
                grant_valid = 1'b1;
                grant       = cand[SW-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_valid) pop[grant] = 1'b1;
    end

    assign next_ptr = (grant == SW'(NUM_SOURCES - 1)) ?
                      '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            wb_en_q <= 1'b0;
            out_q   <= '0;
        end else begin
            wb_en_q <= grant_valid;
            if (grant_valid) begin
                out_q  <= entry_t'(head[grant]);
                rr_ptr <= next_ptr;
            end
        end
    end

    assign bus.wb_en         = wb_en_q;
    assign bus.wb_thread_idx = out_q.thread;
    assign bus.wb_is_vector  = out_q.is_vector;
    assign bus.wb_reg        = out_q.reg_idx;
    assign bus.wb_mask       = out_q.mask;
    assign bus.wb_value      = out_q.value;

    // Lowest index is oldest, so it squashes everything younger.
    always_comb begin
        bus.wb_rollback_en         = 1'b0;
        bus.wb_rollback_thread_idx = '0;
        bus.wb_rollback_pc         = '0;
        bus.wb_rollback_source     = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (bus.src_valid[i] && bus.src_rollback_en[i]) begin
                bus.wb_rollback_en         = 1'b1;
                bus.wb_rollback_thread_idx = bus.src_thread[i];
                bus.wb_rollback_pc         = bus.src_rollback_pc[i];
                bus.wb_rollback_source     = SW'(i);
            end
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (reset)
        (bus.src_valid & ~bus.src_ready) == '0
    );

endmodule

// File: tb/tb_writeback_merge.sv
// Randomized scoreboard bench for writeback_merge against a
// queue-based model of per-source FIFOs and round-robin drain.
module tb_writeback_merge;

    localparam int NS = 3;
    localparam int NL = 16;
    localparam int D  = 2;
    localparam int TW = 2;
    localparam int RW = 5;
    localparam int PW = TW + 1 + RW + NL + NL * 32;

    typedef struct {
        logic [PW-1:0] pl;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    writeback_merge_if #(
        .NUM_SOURCES(NS), .NUM_LANES(NL),
        .THREAD_IDX_BITS(TW), .REG_IDX_BITS(RW)
    ) bus ();

    writeback_merge #(
        .NUM_SOURCES(NS), .NUM_LANES(NL), .FIFO_DEPTH(D),
        .THREAD_IDX_BITS(TW), .REG_IDX_BITS(RW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rr    = 0;

    exp_t          mq [NS][$];
    exp_t          sb [$];
    logic [PW-1:0] last;
    logic [PW-1:0] act;
    exp_t          mon_e;

    logic [NS-1:0]           s_v, s_hd, s_iv, s_ic, s_rb;
    logic [NS-1:0][TW-1:0]   s_th;
    logic [NS-1:0][RW-1:0]   s_rg;
    logic [NS-1:0][NL-1:0]   s_mk;
    logic [NS-1:0][NL-1:0][31:0] s_val;
    logic [NS-1:0][31:0]     s_pc;

    assign act = {bus.wb_thread_idx, bus.wb_is_vector, bus.wb_reg,
                  bus.wb_mask, bus.wb_value};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL missing_write due=%0d now=%0d",
                         mon_e.cyc, cyc);
            end
            total++;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                last  = mon_e.pl;
                if (bus.wb_en !== 1'b1 || act !== mon_e.pl) begin
                    bad++;
                    $display("FAIL write cyc=%0d en=%b got=%h want=%h",
                             cyc, bus.wb_en, act, mon_e.pl);
                end
            end else if (bus.wb_en !== 1'b0 || act !== last) begin
                bad++;
                $display("FAIL idle cyc=%0d en=%b got=%h want=%h",
                         cyc, bus.wb_en, act, last);
            end
        end
    end

    task automatic clear_inputs();
        s_v = '0; s_hd = '0; s_iv = '0; s_ic = '0; s_rb = '0;
        s_th = '0; s_rg = '0; s_mk = '0; s_val = '0; s_pc = '0;
    endtask

    task automatic load(input int i);
        s_v[i]  = 1'b1;
        s_hd[i] = 1'b1;
        s_iv[i] = 1'($urandom);
        s_ic[i] = 1'b0;
        s_rb[i] = 1'b0;
        s_th[i] = TW'($urandom);
        s_rg[i] = RW'($urandom);
        s_mk[i] = NL'($urandom);
        s_pc[i] = $urandom;
        for (int k = 0; k < NL; k++) s_val[i][k] = $urandom;
    endtask

    task automatic step();
        logic [NS-1:0] mrdy;
        logic [NS-1:0] drv;
        logic [TW+35:0] rb_got;
        logic [TW+35:0] rb_want;
        logic [NL*32-1:0] v;
        exp_t e;
        bit found;
        int idx;
        for (int i = 0; i < NS; i++) mrdy[i] = (mq[i].size() < D);
        total++;
        if (bus.src_ready !== mrdy) begin
            bad++;
            $display("FAIL ready cyc=%0d got=%b want=%b",
                     cyc, bus.src_ready, mrdy);
        end
        found = 1'b0;
        for (int j = 0; j < NS; j++) begin
            idx = (rr + j) % NS;
            if (!found && mq[idx].size() > 0) begin
                found = 1'b1;
                e = mq[idx].pop_front();
                e.cyc = cyc + 1;
                sb.push_back(e);
                rr = (idx + 1) % NS;
            end
        end
        drv = s_v & mrdy & bus.src_ready;
        bus.src_valid       = drv;
        bus.src_has_dest    = s_hd;
        bus.src_is_vector   = s_iv;
        bus.src_is_compare  = s_ic;
        bus.src_thread      = s_th;
        bus.src_reg         = s_rg;
        bus.src_mask        = s_mk;
        bus.src_value       = s_val;
        bus.src_rollback_en = s_rb;
        bus.src_rollback_pc = s_pc;
        #1;
        rb_want = '0;
        for (int i = NS - 1; i >= 0; i--)
            if (drv[i] && s_rb[i])
                rb_want = {1'b1, s_th[i], s_pc[i], 2'(i)};
        rb_got = {bus.wb_rollback_en, bus.wb_rollback_thread_idx,
                  bus.wb_rollback_pc, bus.wb_rollback_source};
        total++;
        if (rb_got !== rb_want) begin
            bad++;
            $display("FAIL rollback cyc=%0d got=%h want=%h",
                     cyc, rb_got, rb_want);
        end
        for (int i = 0; i < NS; i++) begin
            if (drv[i] && s_hd[i] && !s_rb[i]) begin
                v = s_val[i];
                if (s_ic[i]) begin
                    v = '0;
                    for (int k = 0; k < NL; k++) v[k] = s_val[i][k][0];
                end
                e.pl  = {s_th[i], s_iv[i], s_rg[i], s_mk[i], v};
                e.cyc = 0;
                mq[i].push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) step();
    endtask

    task automatic do_reset();
        clear_inputs();
        bus.src_valid = '0;
        reset = 1'b1;
        for (int i = 0; i < NS; i++) mq[i].delete();
        sb.delete();
        rr   = 0;
        last = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (bus.wb_en !== 1'b0 || act !== '0) begin
            bad++;
            $display("FAIL reset_out en=%b got=%h want=0",
                     bus.wb_en, act);
        end
    endtask

    task automatic rand_inputs(input int c);
        int p;
        p = (c / 500) % 3;
        clear_inputs();
        for (int i = 0; i < NS; i++) begin
            load(i);
            case (p)
                0:       s_v[i] = ($urandom % 4) == 0;
                1:       s_v[i] = ($urandom % 2) == 0;
                default: s_v[i] = ($urandom % 16) != 0;
            endcase
            s_hd[i] = ($urandom % 8) != 0;
            s_ic[i] = ($urandom % 5) == 0;
            s_rb[i] = ($urandom % 10) == 0;
        end
    endtask

    initial begin
        logic [31:0] tmp;
        clear_inputs();
        bus.src_valid = '0;
        do_reset();
        idle(2);

        load(0);
        s_th[0] = 2'd1; s_rg[0] = 5'd3; s_iv[0] = 1'b0;
        s_val[0][0] = 32'h1234;
        step();
        idle(4);

        do_reset();
        for (int i = 0; i < NS; i++) load(i);
        step();
        idle(5);
        load(0);
        step();
        idle(4);
        for (int i = 0; i < NS; i++) load(i);
        step();
        idle(5);

        repeat (4) begin
            for (int i = 0; i < NS; i++) load(i);
            step();
        end
        idle(14);

        load(1); s_rb[1] = 1'b1; s_th[1] = 2'd0;
        load(2); s_rb[2] = 1'b1; s_th[2] = 2'd3;
        step();
        idle(3);

        load(0);
        s_iv[0] = 1'b1; s_ic[0] = 1'b1;
        for (int k = 0; k < NL; k++) begin
            tmp = $urandom;
            tmp[0] = (k % 2) == 0;
            s_val[0][k] = tmp;
        end
        step();
        idle(4);

        load(0); step();
        load(0); step();
        do_reset();
        idle(4);

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset();
            end else begin
                rand_inputs(c);
                step();
            end
        end
        idle(12);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
